// File: rtl/design_select_pkg.sv
`default_nettype none
// ============================================================================
// Package  : design_select_pkg
// Desc     : Shared types and default sizing for the design-select controller.
// Revision : 1.0 - initial release
// ============================================================================
package design_select_pkg;

    // Controller phases: steady operation, debounce of a new select, and the
    // design reset pulse that follows every commit (and power-on).
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PULSE  = 2'd2
    } state_e;

    localparam int DEF_NUM_IO         = 12;
    localparam int DEF_SEL_W          = 6;
    localparam int DEF_STABLE_CYC     = 4;
    localparam int DEF_SWITCH_RST_CYC = 8;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : design_select_pkg
`default_nettype wire

// File: rtl/design_select_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: design_select_ctrl_if
// Desc     : Pad-side select/io inputs and design-side select/io/reset outputs
//            of the design-select controller.
// Revision : 1.0 - initial release
// ============================================================================
interface design_select_ctrl_if
    import design_select_pkg::*;
#(
    parameter int NUM_IO = DEF_NUM_IO,
    parameter int SEL_W  = DEF_SEL_W
);
    logic [SEL_W-1:0]  des_sel_raw;
    logic [NUM_IO-1:0] io_raw;
    logic              sync_inputs;
    logic              hold_on_switch;
    logic [SEL_W-1:0]  des_sel;
    logic [NUM_IO-1:0] des_io_in;
    logic              des_reset;
    logic              switching;

    // Stimulus side: drives pads and mode bits, observes the controller.
    modport master (
        output des_sel_raw, io_raw, sync_inputs, hold_on_switch,
        input  des_sel, des_io_in, des_reset, switching
    );

    // Controller side.
    modport slave (
        input  des_sel_raw, io_raw, sync_inputs, hold_on_switch,
        output des_sel, des_io_in, des_reset, switching
    );
endinterface : design_select_ctrl_if
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Desc     : Parameterised-width two-flop synchronizer with asynchronous
//            active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/design_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : design_select_ctrl
// Desc     : Commits a pad-level design select to the design mux, issues a
//            fixed-length design reset on every commit and on power-on, and
//            conditions the design inputs (1- or 2-flop path, optional freeze
//            while switching).
// Config   : DES_SEL_DEBOUNCE_EN - when defined, a new select must stay
//            stable for STABLE_CYC cycles before it is committed; otherwise a
//            changed select is committed immediately.
// Revision : 1.0 - initial release
// ============================================================================
module design_select_ctrl
    import design_select_pkg::*;
#(
    parameter int NUM_IO         = DEF_NUM_IO,
    parameter int SEL_W          = DEF_SEL_W,
    parameter int STABLE_CYC     = DEF_STABLE_CYC,
    parameter int SWITCH_RST_CYC = DEF_SWITCH_RST_CYC
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    design_select_ctrl_if.slave bus
);
    // One counter serves both the settle window and the reset pulse; sized so
    // the larger terminal count fits without wrapping.
    localparam int              CNT_W      = $clog2(max_int(STABLE_CYC, SWITCH_RST_CYC)) + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(SWITCH_RST_CYC - 1);
`ifdef DES_SEL_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYC - 1);
`endif

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [SEL_W-1:0]  des_sel_q,   des_sel_d;
    logic              des_reset_q, des_reset_d;
`ifdef DES_SEL_DEBOUNCE_EN
    logic [SEL_W-1:0]  cand_q,      cand_d;
`endif

    logic [NUM_IO-1:0] io_fast_q,   io_fast_d;
    logic              sync_sel_q,  sync_sel_d;
    logic [NUM_IO-1:0] hold_val_q,  hold_val_d;

    logic [SEL_W-1:0]  w_sel_s;
    logic [NUM_IO-1:0] w_io_s2;
    logic [NUM_IO-1:0] w_io_live;
    logic              w_freeze;

    sync2 #(.WIDTH(SEL_W)) u_sel_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (bus.des_sel_raw),
        .q       (w_sel_s)
    );

    sync2 #(.WIDTH(NUM_IO)) u_io_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (bus.io_raw),
        .q       (w_io_s2)
    );

    // Next-state and commit logic; the reset pulse flag follows the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        des_sel_d = des_sel_q;
`ifdef DES_SEL_DEBOUNCE_EN
        cand_d    = cand_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (w_sel_s != des_sel_q) begin
`ifdef DES_SEL_DEBOUNCE_EN
                    state_d = ST_SETTLE;
                    cand_d  = w_sel_s;
                    cnt_d   = '0;
`else
                    state_d   = ST_PULSE;
                    des_sel_d = w_sel_s;
                    cnt_d     = '0;
`endif
                end
            end
`ifdef DES_SEL_DEBOUNCE_EN
            ST_SETTLE: begin
                if (w_sel_s == des_sel_q) begin
                    // Select went back to the committed value: drop the change.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (w_sel_s != cand_q) begin
                    // New candidate restarts the stability window.
                    cand_d = w_sel_s;
                    cnt_d  = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    des_sel_d = cand_q;
                    cnt_d     = '0;
                    state_d   = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_PULSE: begin
                // Select changes are ignored until the pulse has completed.
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
        endcase
        des_reset_d = (state_d == ST_PULSE);
    end

    // Controller state register; reset lands in PULSE for a power-on pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PULSE;
            cnt_q       <= '0;
            des_sel_q   <= '0;
            des_reset_q <= 1'b1;
`ifdef DES_SEL_DEBOUNCE_EN
            cand_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            des_sel_q   <= des_sel_d;
            des_reset_q <= des_reset_d;
`ifdef DES_SEL_DEBOUNCE_EN
            cand_q      <= cand_d;
`endif
        end
    end

    // io path selection and capture of the last value seen while running.
    always_comb begin
        io_fast_d  = bus.io_raw;
        sync_sel_d = bus.sync_inputs;
        w_io_live  = sync_sel_q ? w_io_s2 : io_fast_q;
        hold_val_d = (state_q == ST_RUN) ? w_io_live : hold_val_q;
        w_freeze   = bus.hold_on_switch && (state_q != ST_RUN);
    end

    // io registers: single-flop path, registered mode bit, and freeze value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_fast_q  <= '0;
            sync_sel_q <= 1'b0;
            hold_val_q <= '0;
        end else begin
            io_fast_q  <= io_fast_d;
            sync_sel_q <= sync_sel_d;
            hold_val_q <= hold_val_d;
        end
    end

    assign bus.des_sel   = des_sel_q;
    assign bus.des_reset = des_reset_q;
    assign bus.switching = (state_q != ST_RUN);
    assign bus.des_io_in = w_freeze ? hold_val_q : w_io_live;

endmodule : design_select_ctrl
`default_nettype wire

// File: doc/design_select_ctrl.md
DESIGN_SELECT_CTRL -- requirements
Module: design_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_IO, default 12, width of the design I/O bus.
REQ-002 SHALL have parameter SEL_W, default 6, width of the design-select field.
REQ-003 SHALL have parameter STABLE_CYC, default 4, cycles a new select must hold before commit.
REQ-004 SHALL have parameter SWITCH_RST_CYC, default 8, length of the design reset pulse after commit.
REQ-005 SHALL have port clock  input  1  single clock for all logic; one clock, no other clock domains.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port des_sel_raw  input  SEL_W  unsynchronized design select from pads.
REQ-008 SHALL have port io_raw  input  NUM_IO  unsynchronized design inputs from pads.
REQ-009 SHALL have port sync_inputs  input  1  1 = route io through 2-flop synchronizer, 0 = 1-flop register.
REQ-010 SHALL have port hold_on_switch  input  1  1 = freeze des_io_in while not in RUN.
REQ-011 SHALL have port des_sel  output  SEL_W  committed select driven to the design mux.
REQ-012 SHALL have port des_io_in  output  NUM_IO  conditioned inputs to the selected design.
REQ-013 SHALL have port des_reset  output  1  active-high reset to the design array.
REQ-014 SHALL have port switching  output  1  high in any state other than RUN.

Function
REQ-015 des_sel_raw SHALL pass through a 2-flop synchronizer (sel_s) before any comparison.
REQ-016 FSM SHALL have states RUN, SETTLE, PULSE.
REQ-017 RUN: sel_s != des_sel -> SETTLE, candidate <= sel_s, cnt <= 0.
REQ-018 SETTLE: sel_s == des_sel -> RUN (change aborted, no pulse); sel_s != candidate -> candidate <= sel_s, cnt <= 0; else cnt increments.
REQ-019 SETTLE: cnt == STABLE_CYC-1 with sel_s == candidate -> des_sel <= candidate, cnt <= 0, go PULSE.
REQ-020 PULSE: des_reset = 1; cnt == SWITCH_RST_CYC-1 -> RUN next cycle; des_sel changes ignored until RUN.
REQ-021 des_reset SHALL be registered, high exactly SWITCH_RST_CYC cycles per commit, starting the cycle des_sel updates.
REQ-022 io path: sync_inputs=1 -> 2-cycle latency; sync_inputs=0 -> 1-cycle latency; sync_inputs change takes effect next cycle.
REQ-023 hold_on_switch=1 and state != RUN -> des_io_in holds its last RUN value; hold_on_switch=0 -> io always tracks.
REQ-024 Counters SHALL be sized $clog2(max(STABLE_CYC,SWITCH_RST_CYC))+1 bits and never wrap.

Reset
REQ-025 reset_n low SHALL asynchronously clear synchronizers, des_sel=0, des_io_in=0, cnt=0, candidate=0.
REQ-026 During and after reset state SHALL be PULSE with des_reset=1, switching=1, giving a full SWITCH_RST_CYC power-on pulse after release.
REQ-027 reset_n asserted mid-SETTLE or mid-PULSE SHALL discard the pending candidate.

Configuration
REQ-028 Macro DES_SEL_DEBOUNCE_EN defined: SETTLE state as REQ-018/019.
REQ-029 Macro DES_SEL_DEBOUNCE_EN undefined: no SETTLE state; RUN with sel_s != des_sel commits immediately and enters PULSE; STABLE_CYC unused.

Structure
REQ-030 Package design_select_pkg SHALL hold the state enum and default NUM_IO/SEL_W/STABLE_CYC/SWITCH_RST_CYC constants.
REQ-031 Sub-module sync2 (parameterized-width 2-flop synchronizer, async active-low clear) SHALL be used for select and io paths.

Verification
REQ-032 Reset release, des_sel_raw=0 -> des_reset high 8 cycles, then switching=0, des_sel=0.
REQ-033 des_sel_raw 0->5 held -> des_sel=5 after 2 sync + 4 settle cycles, des_reset high 8 cycles.
REQ-034 des_sel_raw 0->5 for 2 cycles then back to 0 -> no commit, no des_reset pulse, return to RUN.
REQ-035 des_sel_raw 5->3 during PULSE -> pulse completes at 8 cycles, then SETTLE, commit 3 with second pulse.
REQ-036 hold_on_switch=1, io_raw toggled during switch -> des_io_in frozen until RUN; sync_inputs 1 vs 0 -> 2 vs 1 cycle latency.
REQ-037 reset_n pulsed low mid-SETTLE -> des_sel=0, candidate dropped, full power-on pulse follows.
